// File: rtl/nn_frame_loader.sv
// nn_frame_loader: collects a streamed image, one pixel per handshake, converts each pixel to Q8.8, and presents the frame on a wide bus for the network.
// Latency: NNvalid rises on the first clock edge after the last pixel's handshake and stays high for one cycle.
// Backpressure: pixReady is low from FIRE until resultValid returns (waitResult=1), or for the FIRE cycle only (waitResult=0).
//
// Ports:
//   clk, reset               rising-edge clock; asynchronous active-low reset
//   pixIn/pixValid/pixSof    pixel stream; pixSof marks pixel 0 of a frame
//   pixReady                 registered ready; high in IDLE and LOAD
//   resultValid              network result done; releases WAIT
//   NNin                     assembled frame, pixel k at [dataWidth*k +: dataWidth]
//   NNvalid                  one-cycle frame-ready pulse
//   busy                     high in LOAD, FIRE and WAIT
//   frameErr                 one-cycle pulse on an orphan pixel or a mid-frame sof
module nn_frame_loader #(
    parameter int numInputs  = 784,
    parameter int dataWidth  = 16,
    parameter int pixelWidth = 8,
    parameter int pixelShift = 5,
    parameter int waitResult = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [pixelWidth-1:0]          pixIn,
    input  logic                           pixValid,
    input  logic                           pixSof,
    output logic                           pixReady,
    input  logic                           resultValid,
    output logic [dataWidth*numInputs-1:0] NNin,
    output logic                           NNvalid,
    output logic                           busy,
    output logic                           frameErr
);

    localparam int CW = $clog2(numInputs + 1);
    localparam logic [CW-1:0] LAST = CW'(numInputs - 1);

    // A shifted pixel must fit inside one NNin word.
    if (pixelWidth + pixelShift > dataWidth) begin : g_bad_width
        $error("nn_frame_loader: pixelWidth + pixelShift exceeds dataWidth");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FIRE,
        S_WAIT
    } state_t;

    state_t                         r_state;
    state_t                         w_next;
    logic [CW-1:0]                  r_count;
    logic [CW-1:0]                  w_count_nxt;
    logic                           r_rdy;
    logic                           r_nnvalid;
    logic                           r_busy;
    logic                           r_err;
    logic [dataWidth*numInputs-1:0] r_nnin;

    logic                           w_accept;
    logic                           w_wr;
    logic [CW-1:0]                  w_wr_idx;
    logic                           w_err;
    logic [dataWidth-1:0]           w_word;

    assign w_accept = pixValid & r_rdy;
    // Zero-extend first so the shift cannot lose high pixel bits.
    assign w_word   = dataWidth'(pixIn) << pixelShift;

    always_comb begin
        w_next      = r_state;
        w_count_nxt = r_count;
        w_wr        = 1'b0;
        w_wr_idx    = '0;
        w_err       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (pixSof) begin
                        w_wr        = 1'b1;
                        w_count_nxt = CW'(1);
                        // A one-pixel frame is complete on its sof pixel.
                        w_next      = (LAST == '0) ? S_FIRE : S_LOAD;
                    end else begin
                        // Orphan pixel: dropped, NNin untouched.
                        w_err = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (w_accept) begin
                    w_wr = 1'b1;
                    if (pixSof) begin
                        // Restart the frame on the new sof pixel.
                        w_err       = 1'b1;
                        w_count_nxt = CW'(1);
                    end else begin
                        w_wr_idx    = r_count;
                        w_count_nxt = r_count + 1'b1;
                        if (r_count == LAST) begin
                            w_next = S_FIRE;
                        end
                    end
                end
            end
            S_FIRE: begin
                w_count_nxt = '0;
                w_next      = (waitResult != 0) ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                if (resultValid) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up
    // exactly with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_rdy     <= 1'b0;
            r_nnvalid <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_count   <= w_count_nxt;
            r_rdy     <= (w_next == S_IDLE) || (w_next == S_LOAD);
            r_nnvalid <= (w_next == S_FIRE);
            r_busy    <= (w_next != S_IDLE);
            r_err     <= w_err;
        end
    end

    // Frame storage is only written on an accepted pixel, so it holds from
    // FIRE until the next frame starts overwriting it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_nnin <= '0;
        end else if (w_wr) begin
            r_nnin[int'(w_wr_idx) * dataWidth +: dataWidth] <= w_word;
        end
    end

    assign pixReady = r_rdy;
    assign NNin     = r_nnin;
    assign NNvalid  = r_nnvalid;
    assign busy     = r_busy;
    assign frameErr = r_err;

endmodule

// File: tb/tb_nn_frame_loader.sv
module tb_nn_frame_loader;

    localparam int N  = 784;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        pixIn;
    logic              pixValid;
    logic              pixSof;
    logic              resultValid;

    logic              a_rdy, a_nnv, a_busy, a_err;
    logic [DW*N-1:0]   a_nnin;
    logic              b_rdy, b_nnv, b_busy, b_err;
    logic [DW*N-1:0]   b_nnin;

    int checks = 0;
    int errors = 0;
    int na = 0, nb = 0, ea = 0;
    logic use_b = 1'b0;

    always #5 clk = ~clk;

    nn_frame_loader #(.waitResult(1)) u_a (
        .clk(clk), .reset(reset), .pixIn(pixIn), .pixValid(pixValid), .pixSof(pixSof),
        .pixReady(a_rdy), .resultValid(resultValid), .NNin(a_nnin), .NNvalid(a_nnv),
        .busy(a_busy), .frameErr(a_err)
    );

    nn_frame_loader #(.waitResult(0)) u_b (
        .clk(clk), .reset(reset), .pixIn(pixIn), .pixValid(pixValid), .pixSof(pixSof),
        .pixReady(b_rdy), .resultValid(resultValid), .NNin(b_nnin), .NNvalid(b_nnv),
        .busy(b_busy), .frameErr(b_err)
    );

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (a_nnv) na <= na + 1;
        if (b_nnv) nb <= nb + 1;
        if (a_err) ea <= ea + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] wa(input int k);
        return a_nnin[DW*k +: DW];
    endfunction

    function automatic logic [15:0] wb(input int k);
        return b_nnin[DW*k +: DW];
    endfunction

    // Presents one pixel and returns #1 after the edge that accepted it.
    // pixValid is left high so back-to-back pixels have no gaps.
    task automatic push(input logic [7:0] v, input logic sof, input int gap);
        logic r;
        int   n;
        if (gap > 0) begin
            pixValid = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        pixValid = 1'b1;
        pixIn    = v;
        pixSof   = sof;
        n        = 0;
        forever begin
            @(negedge clk);
            r = use_b ? b_rdy : a_rdy;
            @(posedge clk);
            #1;
            if (r) break;
            n++;
            if (n > 50) begin
                chk("push_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic release_wait();
        pixValid    = 1'b0;
        resultValid = 1'b1;
        @(posedge clk);
        #1;
        resultValid = 1'b0;
    endtask

    initial begin
        int ea0, nb0;
        reset       = 1'b0;
        pixIn       = '0;
        pixValid    = 1'b0;
        pixSof      = 1'b0;
        resultValid = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_rdy",   a_rdy,   0);
        chk("rst_nnv",   a_nnv,   0);
        chk("rst_busy",  a_busy,  0);
        chk("rst_err",   a_err,   0);
        chk("rst_nnin",  |a_nnin, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_rdy_after", a_rdy, 1);

        // T1 normal frame, pixValid held high
        for (int k = 0; k < N; k++) push(8'(k % 256), k == 0, 0);
        chk("t1_nnv",    a_nnv,  1);
        chk("t1_busy",   a_busy, 1);
        chk("t1_rdy",    a_rdy,  0);
        chk("t1_w255",   wa(255), 16'h1FE0);
        chk("t1_w1",     wa(1),   16'h0020);
        chk("t1_w0",     wa(0),   16'h0000);
        chk("t1_w783",   wa(783), 16'h01E0);
        @(posedge clk);
        #1;
        chk("t1_nnv_off", a_nnv,  0);
        chk("t1_wait_bz", a_busy, 1);

        // T2 hold-off: pixValid still high, loader must refuse
        repeat (10) @(posedge clk);
        #1;
        chk("t2_rdy",    a_rdy,   0);
        chk("t2_w255",   wa(255), 16'h1FE0);
        chk("t2_w1",     wa(1),   16'h0020);
        chk("t2_nnv_cnt", na,     1);
        release_wait();
        chk("t2_rdy_back", a_rdy,  1);
        chk("t2_idle",     a_busy, 0);

        // T4 orphan pixel in IDLE
        ea0 = ea;
        push(8'hAA, 1'b0, 0);
        chk("t4_err",  a_err,  1);
        chk("t4_busy", a_busy, 0);
        chk("t4_w0",   wa(0),  16'h0000);
        pixValid = 1'b0;
        @(posedge clk);
        #1;
        chk("t4_err_off", a_err, 0);
        chk("t4_err_cnt", ea - ea0, 1);

        // T3 sof reasserted at pixel 100; new frame values (7j+1)%256
        ea0 = ea;
        for (int k = 0; k < 100; k++) push(8'(k % 256), k == 0, 0);
        for (int j = 0; j < N; j++) begin
            push(8'((j * 7 + 1) % 256), j == 0, 0);
            if (j == 0)   chk("t3_err",   a_err, 1);
            if (j == 782) chk("t3_early", a_nnv, 0);
        end
        chk("t3_nnv",  a_nnv,   1);
        chk("t3_w0",   wa(0),   16'h0020);
        chk("t3_w99",  wa(99),  16'h16C0);
        chk("t3_w500", wa(500), 16'h15A0);
        @(posedge clk);
        #1;
        chk("t3_err_cnt", ea - ea0, 1);
        chk("t3_nnv_cnt", na, 2);
        release_wait();

        // T5 reset at pixel 400
        for (int k = 0; k < 400; k++) push(8'(k % 256), k == 0, 0);
        #1;
        reset = 1'b0;
        #1;
        chk("t5_rdy",  a_rdy,   0);
        chk("t5_nnv",  a_nnv,   0);
        chk("t5_busy", a_busy,  0);
        chk("t5_err",  a_err,   0);
        chk("t5_nnin", |a_nnin, 0);
        pixValid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < N; k++) push(8'(k % 256), k == 0, 0);
        chk("t5_nnv_full", a_nnv,   1);
        chk("t5_w255",     wa(255), 16'h1FE0);
        @(posedge clk);
        #1;
        chk("t5_nnv_cnt", na, 3);

        // T6 gapped input on the waitResult=0 instance
        pixValid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        use_b = 1'b1;
        nb0   = nb;
        for (int k = 0; k < N; k++) push(8'(k % 256), k == 0, $urandom_range(0, 2));
        chk("t6_nnv",  b_nnv,   1);
        chk("t6_w255", wb(255), 16'h1FE0);
        chk("t6_w1",   wb(1),   16'h0020);
        pixValid = 1'b1;
        pixSof   = 1'b1;
        pixIn    = 8'd9;
        @(posedge clk);
        #1;
        chk("t6_rdy_after_fire", b_rdy,  1);
        chk("t6_idle",           b_busy, 0);
        chk("t6_nnv_off",        b_nnv,  0);
        @(posedge clk);
        #1;
        pixValid = 1'b0;
        chk("t6_sof_busy", b_busy, 1);
        chk("t6_sof_err",  b_err,  0);
        chk("t6_sof_w0",   wb(0),  16'h0120);
        chk("t6_nnv_cnt",  nb - nb0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
